match_controller: RTL
=====================

// Module: match_controller
// PURPOSE
//  Downstream stage of the tic-tac-toe game core. Consumes the core's winner code and packed board.
//  Detects end of round (win or draw) and keeps per-player scores and a draw count.
//  Holds the finished board visible for a fixed time, then drives the game core's reset to start the next round.
//  Declares a match winner once a player reaches WINS_TO_MATCH.
// PARAMETERS
//  HOLD_CYCLES    50_000_000  cycles the finished board is held before restart (>=2)
//  WINS_TO_MATCH  3           round wins needed to take the match (1..2**SCORE_W-1)
//  SCORE_W        4           width of score/draw counters
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous, active-high reset
//  start         in   1        one-cycle pulse (already edge-detected): begin/rematch
//  winner        in   2        core victory code: 00 none, 01 P1, 10 P2, 11 invalid
//  board         in   18       cells a..i packed, a in [1:0]; 00 empty, 01 P1, 10 P2
//  game_rst      out  1        level reset into game core
//  score_p1      out  SCORE_W  P1 round wins
//  score_p2      out  SCORE_W  P2 round wins
//  draws         out  SCORE_W  drawn rounds
//  round_result  out  2        last round: 00 none, 01 P1, 10 P2, 11 draw
//  hold_active   out  1        high while finished board is held
//  match_over    out  1        high in MATCH_OVER
//  match_winner  out  2        01/10 in MATCH_OVER, else 00
// BEHAVIOUR
//  All outputs registered. Reset (any state) -> IDLE, counters 0, round_result 00, game_rst 1, others 0.
//  FSM:
//   IDLE:       game_rst=1. start -> RESTART.
//   RESTART:    game_rst=1 for exactly one cycle -> PLAY.
//   PLAY:       game_rst=0.
//               winner 01/10 -> bump that score, set round_result, -> HOLD.
//               else all 9 cells !=00 (draw) -> bump draws, round_result=11, -> HOLD.
//               winner 11 ignored.
//   HOLD:       hold_active=1; timer loaded HOLD_CYCLES-1 on entry, decrements.
//               At 0: a score == WINS_TO_MATCH -> MATCH_OVER, else -> RESTART.
//               Total HOLD dwell = HOLD_CYCLES cycles.
//   MATCH_OVER: match_over=1, match_winner = reaching player.
//               start -> clear scores, draws, round_result; -> RESTART.
//  Latency: event sampled at edge N; scores/round_result/hold_active visible after edge N.
//  Simultaneous win and full board -> counted as win, not draw.
//  start ignored in RESTART, PLAY, HOLD.
//  Counters saturate at 2**SCORE_W-1; draws never wraps.
//  Scores persist across rounds; cleared only by rst or rematch start.
//  rst during HOLD aborts timer; no score change.
// CONFIGURATION
//  MATCH_BLINK_EN defined:
//   - adds param BLINK_DIV (default 12_500_000) and output blink.
//   - blink toggles every BLINK_DIV cycles in HOLD and MATCH_OVER; 0 elsewhere and on reset.
//  Undefined: no blink port or logic; hold_active is the only hold indicator.
// STRUCTURE
//  tictactoe_pkg: P_NONE/P1/P2/P_DRAW 2-bit constants; cell_t; mc_state_t enum {IDLE,RESTART,PLAY,HOLD,MATCH_OVER}.
//  Sub-module hold_timer: load/enable down-counter with registered zero flag; reused for blink divider.
// TESTING (HOLD_CYCLES=4, WINS_TO_MATCH=2, SCORE_W=4)
//  1 rst then start -> game_rst 1 in IDLE, 1 cycle in RESTART, 0 in PLAY.
//  2 PLAY, winner=01 -> next cycle: score_p1=1, round_result=01, hold_active=1 for 4 cycles, then RESTART.
//  3 board all non-zero, winner=00 -> draws=1, round_result=11; same board with winner=10 -> score_p2 += 1, draws unchanged.
//  4 P2 wins twice -> after second HOLD: match_over=1, match_winner=10; start -> all counters 0, RESTART.
//  5 rst asserted mid-HOLD -> next cycle IDLE, all outputs at reset values; winner=11 in PLAY -> no change.
//  6 SCORE_W=2, 5 draws -> draws saturates at 3.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared types and constants for the tic-tac-toe match controller.
package match_controller_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t PNone = 2'b00;
  localparam cell_t P1    = 2'b01;
  localparam cell_t P2    = 2'b10;
  localparam cell_t PDraw = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRestart,
    StPlay,
    StHold,
    StMatchOver
  } mc_state_t;

  function automatic logic board_full(input logic [17:0] board);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board[2*i +: 2] == PNone) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bundle between the game core side (master) and the match controller (slave).
// The blink signal exists only when MATCH_BLINK_EN is defined.
interface match_controller_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic [1:0]         winner;
  logic [17:0]        board;
  logic               game_rst;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [SCORE_W-1:0] draws;
  logic [1:0]         round_result;
  logic               hold_active;
  logic               match_over;
  logic [1:0]         match_winner;
`ifdef MATCH_BLINK_EN
  logic               blink;
`endif

  modport master (
    output start, winner, board,
    input  game_rst, score_p1, score_p2, draws, round_result, hold_active, match_over,
    input  match_winner
`ifdef MATCH_BLINK_EN
    , input blink
`endif
  );

  modport slave (
    input  start, winner, board,
    output game_rst, score_p1, score_p2, draws, round_result, hold_active, match_over,
    output match_winner
`ifdef MATCH_BLINK_EN
    , output blink
`endif
  );

endinterface

// File: rtl/match_controller_hold_timer.sv
// Loadable down-counter with a registered zero flag; load wins over enable.
module match_controller_hold_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;
  logic             zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      zero_q  <= 1'b0;
    end else if (load_i) begin
      count_q <= load_val_i;
      zero_q  <= (load_val_i == '0);
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
      zero_q  <= (count_q == Width'(1));
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/match_controller.sv
// Round/match sequencing, scoring and board-hold timing for the tic-tac-toe core.
// Optional MATCH_BLINK_EN adds BLINK_DIV and a blink output toggling in HOLD/MATCH_OVER.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned WINS_TO_MATCH = 3,
  parameter int unsigned SCORE_W       = 4
`ifdef MATCH_BLINK_EN
  , parameter int unsigned BLINK_DIV   = 12_500_000
`endif
) (
  input logic               clk,
  input logic               rst,
  match_controller_if.slave bus
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam logic [SCORE_W-1:0] Wins = SCORE_W'(WINS_TO_MATCH);

  mc_state_t          state_q;
  logic               game_rst_q, hold_active_q, match_over_q;
  logic [SCORE_W-1:0] score_p1_q, score_p2_q, draws_q;
  logic [1:0]         round_result_q, match_winner_q;
  logic               hold_load, hold_en, hold_zero;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    hold_load = (state_q == StPlay) &&
                ((bus.winner == P1) || (bus.winner == P2) || board_full(bus.board));
    hold_en   = (state_q == StHold);
  end

  match_controller_hold_timer #(
    .Width (HoldW)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load),
    .en_i       (hold_en),
    .load_val_i (HoldW'(HOLD_CYCLES - 1)),
    .zero_o     (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      game_rst_q     <= 1'b1;
      hold_active_q  <= 1'b0;
      match_over_q   <= 1'b0;
      match_winner_q <= PNone;
      round_result_q <= PNone;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      draws_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) state_q <= StRestart;
        end
        StRestart: begin
          state_q    <= StPlay;
          game_rst_q <= 1'b0;
        end
        StPlay: begin
          // A win on a full board counts as a win, so winner is checked first.
          if (bus.winner == P1) begin
            score_p1_q     <= sat_inc(score_p1_q);
            round_result_q <= P1;
            hold_active_q  <= 1'b1;
            state_q        <= StHold;
          end else if (bus.winner == P2) begin
            score_p2_q     <= sat_inc(score_p2_q);
            round_result_q <= P2;
            hold_active_q  <= 1'b1;
            state_q        <= StHold;
          end else if (board_full(bus.board)) begin
            draws_q        <= sat_inc(draws_q);
            round_result_q <= PDraw;
            hold_active_q  <= 1'b1;
            state_q        <= StHold;
          end
        end
        StHold: begin
          if (hold_zero) begin
            hold_active_q <= 1'b0;
            if (score_p1_q == Wins) begin
              state_q        <= StMatchOver;
              match_over_q   <= 1'b1;
              match_winner_q <= P1;
            end else if (score_p2_q == Wins) begin
              state_q        <= StMatchOver;
              match_over_q   <= 1'b1;
              match_winner_q <= P2;
            end else begin
              state_q    <= StRestart;
              game_rst_q <= 1'b1;
            end
          end
        end
        StMatchOver: begin
          if (bus.start) begin
            state_q        <= StRestart;
            game_rst_q     <= 1'b1;
            match_over_q   <= 1'b0;
            match_winner_q <= PNone;
            round_result_q <= PNone;
            score_p1_q     <= '0;
            score_p2_q     <= '0;
            draws_q        <= '0;
          end
        end
        default: begin
          state_q    <= StIdle;
          game_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.game_rst     = game_rst_q;
  assign bus.score_p1     = score_p1_q;
  assign bus.score_p2     = score_p2_q;
  assign bus.draws        = draws_q;
  assign bus.round_result = round_result_q;
  assign bus.hold_active  = hold_active_q;
  assign bus.match_over   = match_over_q;
  assign bus.match_winner = match_winner_q;

`ifdef MATCH_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  logic blink_q, blink_act, blink_zero;

  assign blink_act = (state_q == StHold) || (state_q == StMatchOver);

  // Divider stays preloaded while inactive so the first toggle lands BLINK_DIV cycles in.
  match_controller_hold_timer #(
    .Width (BlinkW)
  ) u_blink_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (!blink_act || blink_zero),
    .en_i       (blink_act),
    .load_val_i (BlinkW'(BLINK_DIV - 1)),
    .zero_o     (blink_zero)
  );

  always_ff @(posedge clk) begin
    if (rst || !blink_act) begin
      blink_q <= 1'b0;
    end else if (blink_zero) begin
      blink_q <= ~blink_q;
    end
  end

  assign bus.blink = blink_q;
`endif

endmodule
